// File: rtl/alu_serial_16.sv
// Nibble-serial 74181 ALU: one 4-bit slice per cycle, LSB first, registered ripple carry.
// Optional A_eq_B output (all result nibbles 4'hF) is built only with ALU_SERIAL_AEQB_EN defined.
module alu_serial_16 #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic [3:0]             S,
  input  logic                   M,
  input  logic                   Cn,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   F,
`ifdef ALU_SERIAL_AEQB_EN
  output logic                   A_eq_B,
`endif
  output logic                   Cn_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_f;
  logic [3:0]      r_s;
  logic            r_m;
  logic            r_cn;
  logic [CW-1:0]   r_cnt;
  logic            r_req_ready;
  logic            r_res_valid;
  logic            r_cn_out;
`ifdef ALU_SERIAL_AEQB_EN
  logic            r_aeqb;
`endif

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_x;
  logic [3:0]      w_y;
  logic [3:0]      w_logic;
  logic [4:0]      w_sum;
  logic [3:0]      w_f_nib;
  logic            w_cout_n;

  // One 74181 slice: arithmetic is expressed as x + y + carry, where "-1" terms become all-ones.
  always_comb begin
    w_a_nib = r_a[3:0];
    w_b_nib = r_b[3:0];
    w_x     = w_a_nib;
    w_y     = 4'h0;
    w_logic = 4'h0;
    case (r_s)
      4'h0: begin w_logic = ~w_a_nib;              w_x = w_a_nib;              w_y = 4'h0;               end
      4'h1: begin w_logic = ~(w_a_nib | w_b_nib);  w_x = w_a_nib | w_b_nib;    w_y = 4'h0;               end
      4'h2: begin w_logic = ~w_a_nib & w_b_nib;    w_x = w_a_nib | ~w_b_nib;   w_y = 4'h0;               end
      4'h3: begin w_logic = 4'h0;                  w_x = 4'hF;                 w_y = 4'h0;               end
      4'h4: begin w_logic = ~(w_a_nib & w_b_nib);  w_x = w_a_nib;              w_y = w_a_nib & ~w_b_nib; end
      4'h5: begin w_logic = ~w_b_nib;              w_x = w_a_nib | w_b_nib;    w_y = w_a_nib & ~w_b_nib; end
      4'h6: begin w_logic = w_a_nib ^ w_b_nib;     w_x = w_a_nib;              w_y = ~w_b_nib;           end
      4'h7: begin w_logic = w_a_nib & ~w_b_nib;    w_x = w_a_nib & ~w_b_nib;   w_y = 4'hF;               end
      4'h8: begin w_logic = ~w_a_nib | w_b_nib;    w_x = w_a_nib;              w_y = w_a_nib & w_b_nib;  end
      4'h9: begin w_logic = ~(w_a_nib ^ w_b_nib);  w_x = w_a_nib;              w_y = w_b_nib;            end
      4'hA: begin w_logic = w_b_nib;               w_x = w_a_nib | ~w_b_nib;   w_y = w_a_nib & w_b_nib;  end
      4'hB: begin w_logic = w_a_nib & w_b_nib;     w_x = w_a_nib & w_b_nib;    w_y = 4'hF;               end
      4'hC: begin w_logic = 4'hF;                  w_x = w_a_nib;              w_y = w_a_nib;            end
      4'hD: begin w_logic = w_a_nib | ~w_b_nib;    w_x = w_a_nib | w_b_nib;    w_y = w_a_nib;            end
      4'hE: begin w_logic = w_a_nib | w_b_nib;     w_x = w_a_nib | ~w_b_nib;   w_y = w_a_nib;            end
      default: begin w_logic = w_a_nib;            w_x = w_a_nib;              w_y = 4'hF;               end
    endcase
    w_sum    = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, ~r_cn};
    w_f_nib  = r_m ? w_logic : w_sum[3:0];
    w_cout_n = ~w_sum[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_f         <= '0;
      r_s         <= 4'h0;
      r_m         <= 1'b0;
      r_cn        <= 1'b1;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_cn_out    <= 1'b1;
`ifdef ALU_SERIAL_AEQB_EN
      r_aeqb      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a         <= A;
            r_b         <= B;
            r_s         <= S;
            r_m         <= M;
            r_cn        <= Cn;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          // The cycle after the last slice only publishes flags, giving NIBBLES+1 edges to DONE.
          if (r_cnt == CW'(NIBBLES)) begin
            r_res_valid <= 1'b1;
            r_cn_out    <= r_m ? 1'b1 : r_cn;
`ifdef ALU_SERIAL_AEQB_EN
            r_aeqb      <= &r_f;
`endif
            r_state     <= DONE;
          end else begin
            r_f[4*r_cnt +: 4] <= w_f_nib;
            r_cn              <= w_cout_n;
            r_a               <= r_a >> 4;
            r_b               <= r_b >> 4;
            r_cnt             <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
`ifdef ALU_SERIAL_AEQB_EN
            r_aeqb      <= 1'b0;
`endif
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign res_valid = r_res_valid;
  assign F         = r_f;
  assign Cn_out    = r_cn_out;
`ifdef ALU_SERIAL_AEQB_EN
  assign A_eq_B    = r_aeqb;
`endif

endmodule

// File: tb/tb_alu_serial_16.sv
// Self-checking bench for alu_serial_16: vector table, random vectors, backpressure and mid-op reset.
module tb_alu_serial_16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  S;
  logic        M;
  logic        Cn;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] F;
  logic        Cn_out;
  logic        aeqb;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cn;
    logic [15:0] f;
    logic        co;
    logic        eq;
  } vec_t;

  typedef struct {
    logic [15:0] f;
    logic        co;
    logic        eq;
  } exp_t;

  vec_t tbl[14];
  exp_t sb[$];

  alu_serial_16 #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .A         (A),
    .B         (B),
    .S         (S),
    .M         (M),
    .Cn        (Cn),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .F         (F),
`ifdef ALU_SERIAL_AEQB_EN
    .A_eq_B    (aeqb),
`endif
    .Cn_out    (Cn_out)
  );

`ifndef ALU_SERIAL_AEQB_EN
  assign aeqb = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout, required DUT response", name);
  endtask

  // Full-width reference: 74181 arithmetic is x + y + carry at W bits, logic functions bitwise.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] s, input logic m, input logic cn);
    exp_t        e;
    logic [15:0] x;
    logic [15:0] y;
    logic [16:0] sum;
    e.f = '0; e.co = 1'b1; x = a; y = '0;
    if (m) begin
      case (s)
        4'h0: e.f = ~a;        4'h1: e.f = ~(a | b);  4'h2: e.f = ~a & b;     4'h3: e.f = 16'h0000;
        4'h4: e.f = ~(a & b);  4'h5: e.f = ~b;        4'h6: e.f = a ^ b;      4'h7: e.f = a & ~b;
        4'h8: e.f = ~a | b;    4'h9: e.f = ~(a ^ b);  4'hA: e.f = b;          4'hB: e.f = a & b;
        4'hC: e.f = 16'hFFFF;  4'hD: e.f = a | ~b;    4'hE: e.f = a | b;      default: e.f = a;
      endcase
    end else begin
      case (s)
        4'h0: begin x = a;      y = 16'h0;   end
        4'h1: begin x = a | b;  y = 16'h0;   end
        4'h2: begin x = a | ~b; y = 16'h0;   end
        4'h3: begin x = 16'hFFFF; y = 16'h0; end
        4'h4: begin x = a;      y = a & ~b;  end
        4'h5: begin x = a | b;  y = a & ~b;  end
        4'h6: begin x = a;      y = ~b;      end
        4'h7: begin x = a & ~b; y = 16'hFFFF; end
        4'h8: begin x = a;      y = a & b;   end
        4'h9: begin x = a;      y = b;       end
        4'hA: begin x = a | ~b; y = a & b;   end
        4'hB: begin x = a & b;  y = 16'hFFFF; end
        4'hC: begin x = a;      y = a;       end
        4'hD: begin x = a | b;  y = a;       end
        4'hE: begin x = a | ~b; y = a;       end
        default: begin x = a;   y = 16'hFFFF; end
      endcase
      sum  = {1'b0, x} + {1'b0, y} + {16'h0, ~cn};
      e.f  = sum[15:0];
      e.co = ~sum[16];
    end
    e.eq = (e.f == 16'hFFFF);
    return e;
  endfunction

  // Accepts one request; returns at the falling edge after the accepting edge.
  task automatic start_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                           input logic m, input logic cn, input exp_t e);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) fail_now("req_ready_wait");
    A = a; B = b; S = s; M = m; Cn = cn;
    req_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int   lat;
    exp_t e;
    lat = 0;
    while (!res_valid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!res_valid) begin
      fail_now({name, "_res_valid_wait"});
    end else begin
      check({name, "_latency"}, lat, 5);
      if (sb.size() == 0) begin
        fail_now({name, "_scoreboard_empty"});
      end else begin
        e = sb.pop_front();
        check({name, "_F"}, {16'h0, F}, {16'h0, e.f});
        check({name, "_Cn_out"}, {31'h0, Cn_out}, {31'h0, e.co});
`ifdef ALU_SERIAL_AEQB_EN
        check({name, "_A_eq_B"}, {31'h0, aeqb}, {31'h0, e.eq});
`endif
      end
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    exp_t e;
    e.f = v.f; e.co = v.co; e.eq = v.eq;
    start_req(v.a, v.b, v.s, v.m, v.cn, e);
    wait_res(name);
    consume();
  endtask

  initial begin
    exp_t e;
    vec_t v;
    bit   seen;

    tbl[0]  = '{16'h0003, 16'h0005, 4'h9, 1'b0, 1'b1, 16'h0008, 1'b1, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{16'h1A2B, 16'h1A2B, 4'h6, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
    tbl[3]  = '{16'h1A2C, 16'h1A2B, 4'h6, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{16'hAAAA, 16'hCCCC, 4'h6, 1'b1, 1'b1, 16'h6666, 1'b1, 1'b0};
    tbl[5]  = '{16'hAAAA, 16'hCCCC, 4'h0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0};
    tbl[6]  = '{16'h0003, 16'h0005, 4'h9, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b0};
    tbl[7]  = '{16'h0000, 16'h1234, 4'hF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
    tbl[8]  = '{16'h1234, 16'h0000, 4'hF, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[9]  = '{16'h8001, 16'h0000, 4'hC, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
    tbl[10] = '{16'hF0F0, 16'hFF00, 4'hB, 1'b1, 1'b1, 16'hF000, 1'b1, 1'b0};
    tbl[11] = '{16'h1234, 16'h5678, 4'h3, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[12] = '{16'h1234, 16'h5678, 4'hC, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1};
    tbl[13] = '{16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
    A = '0; B = '0; S = '0; M = 1'b0; Cn = 1'b1;
    #12;
    check("reset_req_ready", {31'h0, req_ready}, 32'd1);
    check("reset_res_valid", {31'h0, res_valid}, 32'd0);
    check("reset_F", {16'h0, F}, 32'h0);
    check("reset_Cn_out", {31'h0, Cn_out}, 32'd1);
`ifdef ALU_SERIAL_AEQB_EN
    check("reset_A_eq_B", {31'h0, aeqb}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 24; i++) begin
      v.a  = 16'($urandom);
      v.b  = 16'($urandom);
      v.s  = 4'($urandom_range(0, 15));
      v.m  = 1'($urandom_range(0, 1));
      v.cn = 1'($urandom_range(0, 1));
      e    = model(v.a, v.b, v.s, v.m, v.cn);
      v.f = e.f; v.co = e.co; v.eq = e.eq;
      run_vec($sformatf("rnd%0d", i), v);
    end

    // Result held under backpressure while a second request is pulsed.
    res_ready = 1'b0;
    start_req(16'h0003, 16'h0005, 4'h9, 1'b0, 1'b1, '{16'h0008, 1'b1, 1'b0});
    wait_res("bp_first");
    for (int i = 0; i < 3; i++) begin
      A = 16'h1111; B = 16'h2222; S = 4'h9; M = 1'b0; Cn = 1'b1;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold%0d_res_valid", i), {31'h0, res_valid}, 32'd1);
      check($sformatf("bp_hold%0d_req_ready", i), {31'h0, req_ready}, 32'd0);
      check($sformatf("bp_hold%0d_F", i), {16'h0, F}, 32'h0008);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_req_ready", {31'h0, req_ready}, 32'd1);
    check("bp_release_res_valid", {31'h0, res_valid}, 32'd0);
    @(posedge clk);
    sb.push_back('{16'h3333, 1'b1, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    wait_res("bp_second");
    consume();

    // Reset during BUSY drops the operation.
    start_req(16'h1234, 16'h4321, 4'h9, 1'b0, 1'b1, '{16'h5555, 1'b1, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("midrst_req_ready", {31'h0, req_ready}, 32'd1);
    check("midrst_res_valid", {31'h0, res_valid}, 32'd0);
    check("midrst_F", {16'h0, F}, 32'h0);
    check("midrst_Cn_out", {31'h0, Cn_out}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("midrst_no_result", {31'h0, seen}, 32'd0);
    run_vec("post_reset", tbl[1]);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
